// File: rtl/servant_uart_tx.sv
// rtl/servant_uart_tx.sv - Wishbone UART transmitter with TX FIFO, 8N1 on o_tx.
// Define SERVANT_UART_TX_PARITY_EN for 8E1 framing (status bit [8] then reads 1).
module servant_uart_tx #(
  parameter int CLK_DIV        = 277,
  parameter int FIFO_DEPTH     = 4,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [7:0]  i_wb_dat,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SERVANT_UART_TX_PARITY_EN
  localparam int   FB       = 11;
  localparam logic PAR_FLAG = 1'b1;
`else
  localparam int   FB       = 10;
  localparam logic PAR_FLAG = 1'b0;
`endif
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(FB - 1);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
  localparam bit          DP_RST    = (RESET_STRATEGY != "NONE");

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, level;
  logic          full, empty;
  logic          accept, push, pop;
  logic          ovf;
  logic [FB-1:0] shift_q, load_word;
  logic [15:0]   baud_cnt;
  logic [3:0]    bit_cnt;
  logic          baud_last, frame_last;
  logic [7:0]    rd_byte;
  logic [31:0]   status;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_byte = mem[rd_ptr[AW-1:0]];

  // The ack register itself blocks a held strobe from being taken twice.
  assign accept = i_wb_cyc & ~o_wb_ack;
  assign push   = accept & i_wb_we & ~full;

  assign baud_last  = (baud_cnt == BAUD_LAST);
  assign frame_last = (bit_cnt == BIT_LAST);

`ifdef SERVANT_UART_TX_PARITY_EN
  assign load_word = {1'b1, ^rd_byte, rd_byte, 1'b0};
`else
  assign load_word = {1'b1, rd_byte, 1'b0};
`endif

  assign status = {23'd0, PAR_FLAG, ovf, (state_q != IDLE), empty, full, 4'(level)};

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A waiting byte is chained straight onto the stop bit with no idle gap.
        if (baud_last && frame_last) begin
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      o_wb_ack <= accept;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (accept && i_wb_we && full)  ovf <= 1'b1;
      else if (accept && !i_wb_we)    ovf <= 1'b0;
      if (accept && !i_wb_we) o_wb_rdt <= status;
      if (pop) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state_q == SHIFT) begin
        if (baud_last) begin
          baud_cnt <= '0;
          bit_cnt  <= bit_cnt + 4'd1;
        end else begin
          baud_cnt <= baud_cnt + 16'd1;
        end
      end
    end
  end

  // Datapath storage; left unreset when RESET_STRATEGY is "NONE".
  always_ff @(posedge i_clk) begin
    if (i_rst && DP_RST) begin
      shift_q <= '1;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push) mem[wr_ptr[AW-1:0]] <= i_wb_dat;
      if (pop)
        shift_q <= load_word;
      else if (state_q == SHIFT && baud_last)
        shift_q <= {1'b1, shift_q[FB-1:1]};
    end
  end

  assign o_tx   = (state_q == SHIFT) ? shift_q[0] : 1'b1;
  assign o_busy = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_servant_uart_tx.sv
// tb/tb_servant_uart_tx.sv - scoreboard bench for servant_uart_tx (CLK_DIV=4, FIFO_DEPTH=4)
`timescale 1ns/1ps
module tb_servant_uart_tx;

  localparam int DIV = 4;
`ifdef SERVANT_UART_TX_PARITY_EN
  localparam int          FB  = 11;
  localparam logic [31:0] PAR = 32'h100;
`else
  localparam int          FB  = 10;
  localparam logic [31:0] PAR = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_we = 1'b0;
  logic [7:0]  i_wb_dat = 8'h00;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack, o_tx, o_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_status[$];
  int          starts[$];
  logic        rx_active = 1'b0;
  logic        last_parity = 1'b0;

  servant_uart_tx #(
    .CLK_DIV(DIV),
    .FIFO_DEPTH(4),
    .RESET_STRATEGY("MINI")
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_wb_cyc(i_wb_cyc),
    .i_wb_we(i_wb_we),
    .i_wb_dat(i_wb_dat),
    .o_wb_rdt(o_wb_rdt),
    .o_wb_ack(o_wb_ack),
    .o_tx(o_tx),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wb_write(input logic [7:0] d, input bit lands, output int acc);
    i_wb_cyc = 1'b1;
    i_wb_we  = 1'b1;
    i_wb_dat = d;
    if (lands) exp_bytes.push_back(d);
    @(posedge clk); #1;
    acc = cyc;
    i_wb_cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [31:0] exp);
    exp_status.push_back(exp);
    i_wb_cyc = 1'b1;
    i_wb_we  = 1'b0;
    @(posedge clk); #1;
    i_wb_cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int max);
    int k;
    k = 0;
    while ((o_busy || rx_active || exp_bytes.size() != 0) && k < max) begin
      @(negedge clk);
      k++;
    end
    check("drain_in_time", (k < max), 1);
    @(posedge clk); #1;
  endtask

  // Status scoreboard: a read accepted at an edge must ack with the queued word.
  initial begin : status_mon
    logic pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("status_ack", o_wb_ack, 1);
        if (exp_status.size() == 0) begin
          checks++; failures++;
          $display("FAIL status_unexpected: got 0x%0h expected none", o_wb_rdt);
        end else begin
          check("status_word", o_wb_rdt, exp_status.pop_front());
        end
      end
      pend = i_wb_cyc && !o_wb_ack && !i_wb_we && !i_rst;
    end
  end

  // Line receiver: samples each bit one cycle into its DIV-cycle slot.
  initial begin : line_mon
    logic       prev;
    int         n, bi;
    logic [7:0] b;
    prev = 1'b1; n = 0; bi = 0; b = '0;
    forever begin
      @(negedge clk);
      if (!rx_active) begin
        if (prev === 1'b1 && o_tx === 1'b0 && !i_rst) begin
          rx_active = 1'b1;
          n = 0;
          b = '0;
          starts.push_back(cyc);
        end
      end else if (i_rst) begin
        rx_active = 1'b0;
      end else begin
        n++;
        if (n % DIV == 1) begin
          bi = n / DIV;
          if (bi == 0) begin
            check("start_bit", o_tx, 0);
          end else if (bi <= 8) begin
            b[bi-1] = o_tx;
          end else if (bi == FB - 1) begin
            check("stop_bit", o_tx, 1);
            if (exp_bytes.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_frame: got 0x%0h expected none", b);
            end else begin
              check("rx_byte", b, exp_bytes.pop_front());
            end
            rx_active = 1'b0;
          end
`ifdef SERVANT_UART_TX_PARITY_EN
          else if (bi == 9) begin
            last_parity = o_tx;
            check("parity_bit", o_tx, ^b);
          end
`endif
        end
      end
      prev = o_tx;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc, a0, n_ack, bad;
    logic [3:0] pat;

    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("rst_tx", o_tx, 1);
    check("rst_ack", o_wb_ack, 0);
    check("rst_busy", o_busy, 0);
    repeat (100) @(posedge clk);
    #1;
    check("idle_tx", o_tx, 1);
    check("idle_busy", o_busy, 0);
    wb_read(32'h20 | PAR);

    // Single frame 0x55: start edge one cycle after push, FB*DIV cycles long.
    starts.delete();
    wb_write(8'h55, 1'b1, acc);
    while (cyc < acc + FB * DIV) @(negedge clk);
    check("frame_last_busy", o_busy, 1);
    check("frame_last_tx", o_tx, 1);
    @(negedge clk);
    check("frame_end_busy", o_busy, 0);
    check("frame_count_55", starts.size(), 1);
    if (starts.size() > 0) check("start_latency", starts[0] - acc, 1);
    @(posedge clk); #1;

    // Six writes into a 4-deep FIFO while the first frame is on the line.
    starts.delete();
    wb_write(8'h01, 1'b1, a0);
    wb_write(8'h02, 1'b1, acc);
    wb_write(8'h03, 1'b1, acc);
    wb_write(8'h04, 1'b1, acc);
    wb_write(8'h05, 1'b1, acc);
    wb_write(8'h06, 1'b0, acc);
    wb_read(32'hD4 | PAR);
    wb_read(32'h54 | PAR);
    wait_drain(2000);
    check("b2b_frames", starts.size(), 5);
    for (int i = 1; i < starts.size(); i++) check("b2b_gap", starts[i] - starts[i-1], FB * DIV);
    wb_read(32'h20 | PAR);

    // Strobe held for four cycles: accepts on the 1st and 3rd edges only.
    i_wb_cyc = 1'b1;
    i_wb_we  = 1'b1;
    i_wb_dat = 8'h11;
    exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h12);
    n_ack = 0;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = o_wb_ack;
      if (o_wb_ack) n_ack++;
      if (i == 0) i_wb_dat = 8'h12;
    end
    i_wb_cyc = 1'b0;
    check("held_ack_count", n_ack, 2);
    check("held_ack_pattern", pat, 4'b0101);
    wait_drain(2000);
    wb_read(32'h20 | PAR);

    // Reset during data bit 2 of 0xA3 with two bytes still queued.
    wb_write(8'hA3, 1'b0, acc);
    wb_write(8'hB4, 1'b0, a0);
    wb_write(8'hC5, 1'b0, a0);
    while (cyc < acc + 14) begin @(posedge clk); #1; end
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    check("midrst_tx", o_tx, 1);
    check("midrst_busy", o_busy, 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_tx !== 1'b1) bad++;
    end
    check("midrst_quiet", bad, 0);
    @(posedge clk); #1;
    wb_read(32'h20 | PAR);

`ifdef SERVANT_UART_TX_PARITY_EN
    wb_write(8'h07, 1'b1, acc);
    while (cyc < acc + 44) @(negedge clk);
    check("par_frame_busy", o_busy, 1);
    @(negedge clk);
    check("par_frame_end", o_busy, 0);
    check("par_bit_07", last_parity, 1);
    @(posedge clk); #1;
    wb_read(32'h120);
`endif

    wait_drain(500);
    check("status_queue_empty", exp_status.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
